// File: rtl/idma_arb_pkg.sv
// Shared types and constants for the iDMA channel arbiter.
package idma_arb_pkg;

    localparam int unsigned MaxChannels = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } gnt_state_e;

    // Channel index width; never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with optional fall-through; DEPTH must be a power of two.
module stream_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         data_t       = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  data_t data_i,
    input  logic  valid_i,
    output logic  ready_o,
    output data_t data_o,
    output logic  valid_o,
    input  logic  ready_i
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned UsageW = AddrW + 1;

    logic [AddrW-1:0]  wr_q, rd_q;
    logic [UsageW-1:0] usage_q;
    data_t             mem_q [DEPTH];
    logic              empty, push, pop;

    assign empty   = (usage_q == '0);
    assign ready_o = (usage_q != UsageW'(DEPTH));

    generate
        if (FALL_THROUGH) begin : g_ft
            // An empty FIFO forwards the input straight through without storing it.
            assign valid_o = !empty || valid_i;
            assign data_o  = empty ? data_i : mem_q[rd_q];
            assign push    = valid_i && ready_o && !(empty && ready_i);
            assign pop     = ready_i && !empty;
        end else begin : g_reg
            assign valid_o = !empty;
            assign data_o  = mem_q[rd_q];
            assign push    = valid_i && ready_o;
            assign pop     = ready_i && !empty;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            usage_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AddrW'(1);
            if (pop)  rd_q <= rd_q + AddrW'(1);
            if (push && !pop)      usage_q <= usage_q + UsageW'(1);
            else if (pop && !push) usage_q <= usage_q - UsageW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/idma_channel_arbiter.sv
// Round-robin arbiter sharing one iDMA backend among several frontend channels.
// Optional per-channel completion statistics: define IDMA_CHANNEL_ARBITER_STATS_EN.
module idma_channel_arbiter
    import idma_arb_pkg::*;
#(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned CmplFifoDepth = 8,
    parameter type         idma_req_t    = logic,
    parameter type         idma_rsp_t    = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  idma_req_t              ch_req_i       [NumChannels],
    input  logic [NumChannels-1:0] ch_req_valid_i,
    output logic [NumChannels-1:0] ch_req_ready_o,
    output idma_rsp_t              ch_rsp_o       [NumChannels],
    output logic [NumChannels-1:0] ch_rsp_valid_o,
    input  logic [NumChannels-1:0] ch_rsp_ready_i,
    output idma_req_t              be_req_o,
    output logic                   be_req_valid_o,
    input  logic                   be_req_ready_i,
    input  idma_rsp_t              be_rsp_i,
    input  logic                   be_rsp_valid_i,
    output logic                   be_rsp_ready_o,
    output logic [NumChannels-1:0] ch_busy_o,
    output logic                   busy_o
`ifdef IDMA_CHANNEL_ARBITER_STATS_EN
    ,
    output logic [NumChannels-1:0][31:0] ch_jobs_done_o
`endif
);

    localparam int unsigned IdxW = idx_width(NumChannels);
    localparam int unsigned CntW = $clog2(CmplFifoDepth + 1);

    typedef logic [IdxW-1:0] idx_t;

    gnt_state_e             state_q, state_d;
    idx_t                   rr_q, rr_d, gnt_q, gnt_d;
    idx_t                   sel_idx, head_idx;
    logic                   sel_valid, req_hs, rsp_hs;
    logic                   fifo_ready, fifo_valid;
    logic [NumChannels-1:0] cnt_inc, cnt_dec;
    logic [CntW-1:0]        cnt_q [NumChannels];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Grant selection and backend request; a held grant cannot be pre-empted.
    always_comb begin : p_grant
        int unsigned cand;
        state_d        = state_q;
        rr_d           = rr_q;
        gnt_d          = gnt_q;
        sel_idx        = gnt_q;
        sel_valid      = 1'b0;
        cand           = 0;
        ch_req_ready_o = '0;

        if (state_q == HELD) begin
            sel_valid = ch_req_valid_i[gnt_q];
        end else begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                cand = 32'(rr_q) + i;
                if (cand >= NumChannels) cand = cand - NumChannels;
                if (!sel_valid && ch_req_valid_i[IdxW'(cand)]) begin
                    sel_valid = 1'b1;
                    sel_idx   = IdxW'(cand);
                end
            end
        end

        be_req_o       = ch_req_i[sel_idx];
        be_req_valid_o = rst_ni && sel_valid && fifo_ready;
        if (be_req_valid_o) ch_req_ready_o[sel_idx] = be_req_ready_i;
        req_hs = be_req_valid_o && be_req_ready_i;

        case (state_q)
            IDLE: if (be_req_valid_o && !be_req_ready_i) begin
                state_d = HELD;
                gnt_d   = sel_idx;
            end
            HELD: if (req_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (req_hs) rr_d = (32'(sel_idx) == NumChannels - 1) ? '0 : sel_idx + IdxW'(1);
    end

    stream_fifo #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (CmplFifoDepth),
        .data_t       (idx_t)
    ) i_cmpl_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (sel_idx),
        .valid_i (req_hs),
        .ready_o (fifo_ready),
        .data_o  (head_idx),
        .valid_o (fifo_valid),
        .ready_i (rsp_hs)
    );

    // Responses return in issue order, so the FIFO head owns the backend response.
    always_comb begin : p_rsp
        ch_rsp_valid_o = '0;
        for (int unsigned k = 0; k < NumChannels; k++) ch_rsp_o[k] = '0;
        be_rsp_ready_o = fifo_valid && ch_rsp_ready_i[head_idx];
        if (fifo_valid) begin
            ch_rsp_o[head_idx]       = be_rsp_i;
            ch_rsp_valid_o[head_idx] = be_rsp_valid_i;
        end
        rsp_hs = be_rsp_valid_i && be_rsp_ready_o;
    end

    always_comb begin : p_cnt_ctrl
        cnt_inc = '0;
        cnt_dec = '0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            cnt_inc[k] = req_hs && (sel_idx == IdxW'(k));
            cnt_dec[k] = rsp_hs && (head_idx == IdxW'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NumChannels; k++) cnt_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NumChannels; k++) begin
                if (cnt_inc[k] && !cnt_dec[k])      cnt_q[k] <= cnt_q[k] + CntW'(1);
                else if (cnt_dec[k] && !cnt_inc[k]) cnt_q[k] <= cnt_q[k] - CntW'(1);
            end
        end
    end

    always_comb begin : p_busy
        ch_busy_o = '0;
        for (int unsigned k = 0; k < NumChannels; k++) ch_busy_o[k] = (cnt_q[k] != '0);
        busy_o = |ch_busy_o;
    end

`ifdef IDMA_CHANNEL_ARBITER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_jobs_done_o <= '0;
        end else begin
            for (int unsigned k = 0; k < NumChannels; k++) begin
                if (cnt_dec[k]) ch_jobs_done_o[k] <= ch_jobs_done_o[k] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_idma_channel_arbiter.sv
// Directed, table-driven bench for idma_channel_arbiter (4 channels, 8-deep completion FIFO).
module tb_idma_channel_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned D = 8;

    typedef logic [15:0] word_t;

    typedef struct {
        logic [3:0] valid;
        logic       be_rdy;
        logic [3:0] rsp_rdy;
        logic       rsp_v;
        logic       e_bv;
        word_t      e_breq;
        logic [3:0] e_crdy;
        logic       e_brr;
        logic [3:0] e_crv;
        logic [3:0] e_busy;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    word_t      ch_req [N];
    logic [3:0] ch_req_valid, ch_req_ready;
    word_t      ch_rsp [N];
    logic [3:0] ch_rsp_valid, ch_rsp_ready;
    word_t      be_req, be_rsp;
    logic       be_req_valid, be_req_ready;
    logic       be_rsp_valid, be_rsp_ready;
    logic [3:0] ch_busy;
    logic       busy;
`ifdef IDMA_CHANNEL_ARBITER_STATS_EN
    logic [N-1:0][31:0] jobs_done;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    vec_t tbl [24];

    always #5 clk_i = ~clk_i;

    idma_channel_arbiter #(
        .NumChannels   (N),
        .CmplFifoDepth (D),
        .idma_req_t    (word_t),
        .idma_rsp_t    (word_t)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ch_req_i       (ch_req),
        .ch_req_valid_i (ch_req_valid),
        .ch_req_ready_o (ch_req_ready),
        .ch_rsp_o       (ch_rsp),
        .ch_rsp_valid_o (ch_rsp_valid),
        .ch_rsp_ready_i (ch_rsp_ready),
        .be_req_o       (be_req),
        .be_req_valid_o (be_req_valid),
        .be_req_ready_i (be_req_ready),
        .be_rsp_i       (be_rsp),
        .be_rsp_valid_i (be_rsp_valid),
        .be_rsp_ready_o (be_rsp_ready),
        .ch_busy_o      (ch_busy),
        .busy_o         (busy)
`ifdef IDMA_CHANNEL_ARBITER_STATS_EN
        ,
        .ch_jobs_done_o (jobs_done)
`endif
    );

    function automatic vec_t mk(logic [3:0] valid, logic be_rdy, logic [3:0] rsp_rdy, logic rsp_v,
                                logic e_bv, word_t e_breq, logic [3:0] e_crdy, logic e_brr,
                                logic [3:0] e_crv, logic [3:0] e_busy);
        vec_t v;
        v.valid = valid;   v.be_rdy = be_rdy; v.rsp_rdy = rsp_rdy; v.rsp_v = rsp_v;
        v.e_bv  = e_bv;    v.e_breq = e_breq; v.e_crdy  = e_crdy;  v.e_brr = e_brr;
        v.e_crv = e_crv;   v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(logic [3:0] valid, logic be_rdy, logic [3:0] rsp_rdy, logic rsp_v, word_t rsp);
        ch_req_valid = valid;
        be_req_ready = be_rdy;
        ch_rsp_ready = rsp_rdy;
        be_rsp_valid = rsp_v;
        be_rsp       = rsp;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(string name, logic e_bv, word_t e_breq, logic [3:0] e_crdy, logic e_brr,
                         logic [3:0] e_crv, logic [3:0] e_busy);
        logic  bad;
        word_t exp_rsp;
        bad = 1'b0;
        n_vec++;
        if (be_req_valid !== e_bv) bad = 1'b1;
        if (e_bv && (be_req !== e_breq)) bad = 1'b1;
        if (ch_req_ready !== e_crdy) bad = 1'b1;
        if (be_rsp_ready !== e_brr) bad = 1'b1;
        if (ch_rsp_valid !== e_crv) bad = 1'b1;
        if (ch_busy !== e_busy) bad = 1'b1;
        if (busy !== (|e_busy)) bad = 1'b1;
        if (e_crv != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                exp_rsp = e_crv[k] ? be_rsp : 16'h0000;
                if (ch_rsp[k] !== exp_rsp) bad = 1'b1;
            end
        end
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got bv=%b req=%h crdy=%b brr=%b crv=%b busy=%b/%b rsp=%h,%h,%h,%h; want bv=%b req=%h crdy=%b brr=%b crv=%b busy=%b",
                     name, be_req_valid, be_req, ch_req_ready, be_rsp_ready, ch_rsp_valid, ch_busy, busy,
                     ch_rsp[0], ch_rsp[1], ch_rsp[2], ch_rsp[3],
                     e_bv, e_breq, e_crdy, e_brr, e_crv, e_busy);
        end
    endtask

`ifdef IDMA_CHANNEL_ARBITER_STATS_EN
    task automatic check_stats(string name, logic [31:0] expv);
        n_vec++;
        if (jobs_done[0] !== expv || jobs_done[1] !== expv || jobs_done[2] !== expv || jobs_done[3] !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d %0d %0d %0d, want %0d each", name,
                     jobs_done[0], jobs_done[1], jobs_done[2], jobs_done[3], expv);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] seen;
        int         ch;
        for (int k = 0; k < 4; k++) ch_req[k] = 16'hA000 + 16'(k);

        // Sequence: round-robin, held grant, in-order routing, stalled head.
        tbl[0]  = mk(4'b0101, 1, 4'hF, 0,  1, 16'hA000, 4'b0001, 0, 4'b0000, 4'b0000);
        tbl[1]  = mk(4'b0100, 1, 4'hF, 0,  1, 16'hA002, 4'b0100, 1, 4'b0000, 4'b0001);
        tbl[2]  = mk(4'b0000, 1, 4'hF, 1,  0, 16'h0000, 4'b0000, 1, 4'b0001, 4'b0101);
        tbl[3]  = mk(4'b0000, 1, 4'hF, 1,  0, 16'h0000, 4'b0000, 1, 4'b0100, 4'b0100);
        tbl[4]  = mk(4'b0010, 0, 4'hF, 0,  1, 16'hA001, 4'b0000, 0, 4'b0000, 4'b0000);
        tbl[5]  = mk(4'b0011, 0, 4'hF, 0,  1, 16'hA001, 4'b0000, 0, 4'b0000, 4'b0000);
        tbl[6]  = mk(4'b0011, 0, 4'hF, 0,  1, 16'hA001, 4'b0000, 0, 4'b0000, 4'b0000);
        tbl[7]  = mk(4'b0011, 1, 4'hF, 0,  1, 16'hA001, 4'b0010, 0, 4'b0000, 4'b0000);
        tbl[8]  = mk(4'b0001, 1, 4'hF, 0,  1, 16'hA000, 4'b0001, 1, 4'b0000, 4'b0010);
        tbl[9]  = mk(4'b0000, 1, 4'hF, 1,  0, 16'h0000, 4'b0000, 1, 4'b0010, 4'b0011);
        tbl[10] = mk(4'b0000, 1, 4'hF, 1,  0, 16'h0000, 4'b0000, 1, 4'b0001, 4'b0001);
        tbl[11] = mk(4'b1000, 1, 4'hF, 0,  1, 16'hA003, 4'b1000, 0, 4'b0000, 4'b0000);
        tbl[12] = mk(4'b0010, 1, 4'hF, 0,  1, 16'hA001, 4'b0010, 1, 4'b0000, 4'b1000);
        tbl[13] = mk(4'b1000, 1, 4'hF, 0,  1, 16'hA003, 4'b1000, 1, 4'b0000, 4'b1010);
        tbl[14] = mk(4'b0000, 1, 4'hF, 0,  0, 16'h0000, 4'b0000, 1, 4'b0000, 4'b1010);
        tbl[15] = mk(4'b0000, 1, 4'hF, 1,  0, 16'h0000, 4'b0000, 1, 4'b1000, 4'b1010);
        tbl[16] = mk(4'b0000, 1, 4'hF, 1,  0, 16'h0000, 4'b0000, 1, 4'b0010, 4'b1010);
        tbl[17] = mk(4'b0000, 1, 4'hF, 1,  0, 16'h0000, 4'b0000, 1, 4'b1000, 4'b1000);
        tbl[18] = mk(4'b0000, 1, 4'hF, 0,  0, 16'h0000, 4'b0000, 0, 4'b0000, 4'b0000);
        tbl[19] = mk(4'b0100, 1, 4'hF, 0,  1, 16'hA002, 4'b0100, 0, 4'b0000, 4'b0000);
        tbl[20] = mk(4'b0000, 1, 4'hB, 1,  0, 16'h0000, 4'b0000, 0, 4'b0100, 4'b0100);
        tbl[21] = mk(4'b0000, 1, 4'hB, 1,  0, 16'h0000, 4'b0000, 0, 4'b0100, 4'b0100);
        tbl[22] = mk(4'b0000, 1, 4'hF, 1,  0, 16'h0000, 4'b0000, 1, 4'b0100, 4'b0100);
        tbl[23] = mk(4'b0000, 1, 4'hF, 0,  0, 16'h0000, 4'b0000, 0, 4'b0000, 4'b0000);

        // Outputs quiet during reset even with every input asserted.
        rst_ni = 1'b0;
        drive(4'hF, 1, 4'hF, 1, 16'h5EED);
        @(negedge clk_i);
        check("reset_quiet", 0, 16'h0000, 4'b0000, 0, 4'b0000, 4'b0000);
        next_cycle();
        rst_ni = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].valid, tbl[i].be_rdy, tbl[i].rsp_rdy, tbl[i].rsp_v, 16'h5000 + 16'(i));
            @(negedge clk_i);
            check($sformatf("vec%0d", i), tbl[i].e_bv, tbl[i].e_breq, tbl[i].e_crdy,
                  tbl[i].e_brr, tbl[i].e_crv, tbl[i].e_busy);
            next_cycle();
        end

        // Fill the completion FIFO: rr starts at 3, so order is 3,0,1,2,3,0,1,2.
        seen = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            ch = (3 + i) % 4;
            drive(4'hF, 1, 4'hF, 0, 16'h6000);
            @(negedge clk_i);
            check($sformatf("fill%0d", i), 1, 16'hA000 + 16'(ch), 4'(1 << ch), (i != 0), 4'b0000, seen);
            seen[ch] = 1'b1;
            next_cycle();
        end
        drive(4'hF, 1, 4'hF, 0, 16'h6001);
        @(negedge clk_i);
        check("full_stall", 0, 16'h0000, 4'b0000, 1, 4'b0000, 4'b1111);
        next_cycle();
        drive(4'hF, 1, 4'hF, 1, 16'h6002);
        @(negedge clk_i);
        check("full_pop_same_cycle", 0, 16'h0000, 4'b0000, 1, 4'b1000, 4'b1111);
        next_cycle();
        drive(4'hF, 1, 4'hF, 0, 16'h6003);
        @(negedge clk_i);
        check("issue_resumes", 1, 16'hA003, 4'b1000, 1, 4'b0000, 4'b1111);
        next_cycle();

        // Drain three responses (heads 0,1,2), leaving five in flight.
        for (int i = 0; i < 3; i++) begin
            drive(4'h0, 1, 4'hF, 1, 16'h7000 + 16'(i));
            @(negedge clk_i);
            check($sformatf("drain%0d", i), 0, 16'h0000, 4'b0000, 1, 4'(1 << i), 4'b1111);
            next_cycle();
        end
`ifdef IDMA_CHANNEL_ARBITER_STATS_EN
        drive(4'h0, 1, 4'hF, 0, 16'h0000);
        #1;
        check_stats("jobs_done_before_reset", 32'd3);
`endif

        // One-cycle reset with five jobs in flight.
        rst_ni = 1'b0;
        drive(4'hF, 1, 4'hF, 1, 16'h8000);
        @(negedge clk_i);
        check("midop_reset", 0, 16'h0000, 4'b0000, 0, 4'b0000, 4'b0000);
`ifdef IDMA_CHANNEL_ARBITER_STATS_EN
        check_stats("jobs_done_in_reset", 32'd0);
`endif
        next_cycle();
        rst_ni = 1'b1;
        drive(4'h0, 1, 4'hF, 1, 16'h8001);
        @(negedge clk_i);
        check("post_reset_fifo_empty", 0, 16'h0000, 4'b0000, 0, 4'b0000, 4'b0000);
        next_cycle();
        drive(4'hF, 1, 4'hF, 0, 16'h8002);
        @(negedge clk_i);
        check("post_reset_rr_zero", 1, 16'hA000, 4'b0001, 0, 4'b0000, 4'b0000);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/idma_channel_arbiter.md
IDMA_CHANNEL_ARBITER -- requirements
Module: idma_channel_arbiter

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of frontend channels sharing one backend (2..16).
REQ-002 SHALL have parameter CmplFifoDepth, default 8, maximum backend jobs in flight (power of two, >=2).
REQ-003 SHALL have parameters idma_req_t and idma_rsp_t, default logic, the iDMA burst request and response types.
REQ-004 SHALL have port clk_i, input, 1, the only clock.
REQ-005 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port ch_req_i, input, NumChannels x idma_req_t, the per-channel job.
REQ-007 SHALL have ports ch_req_valid_i (input) and ch_req_ready_o (output), NumChannels each, the per-channel job handshake.
REQ-008 SHALL have port ch_rsp_o, output, NumChannels x idma_rsp_t, the per-channel completion.
REQ-009 SHALL have ports ch_rsp_valid_o (output) and ch_rsp_ready_i (input), NumChannels each.
REQ-010 SHALL have ports be_req_o (output, idma_req_t), be_req_valid_o (output, 1) and be_req_ready_i (input, 1), the backend request.
REQ-011 SHALL have ports be_rsp_i (input, idma_rsp_t), be_rsp_valid_i (input, 1) and be_rsp_ready_o (output, 1), the backend response.
REQ-012 SHALL have port ch_busy_o, output, NumChannels, set while the channel has at least one job in flight.
REQ-013 SHALL have port busy_o, output, 1, the OR of ch_busy_o.

Function
REQ-014 SHALL use a grant FSM with two states. In IDLE, the winner is picked combinationally among valid channels, round-robin, starting at the pointer rr_q.
REQ-015 SHALL move IDLE->HELD when be_req_valid_o=1 and be_req_ready_i=0, latching the winner in gnt_q. HELD->IDLE SHALL occur on the backend handshake.
REQ-016 SHALL keep be_req_o and be_req_valid_o driven from gnt_q in HELD. A newly valid channel SHALL NOT pre-empt the held grant.
REQ-017 SHALL drive ch_req_ready_o[k] = be_req_ready_i only for the granted channel k, and 0 for every other channel.
REQ-018 SHALL set rr_q to (k+1) mod NumChannels on the handshake for channel k, and SHALL NOT change rr_q otherwise.
REQ-019 SHALL push the granted channel index into the completion FIFO on every backend request handshake, with 0-cycle added latency from ch_req_valid_i to be_req_valid_o.
REQ-020 SHALL force be_req_valid_o=0 and all ch_req_ready_o=0 while the FIFO is full, even if a pop occurs in the same cycle.
REQ-021 SHALL route be_rsp_i to ch_rsp_o[head] with ch_rsp_valid_o[head]=be_rsp_valid_i and be_rsp_ready_o=ch_rsp_ready_i[head]; on an empty FIFO, be_rsp_ready_o=0.
REQ-022 SHALL pop the FIFO on the backend response handshake. A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-023 SHALL keep one outstanding counter per channel, width $clog2(CmplFifoDepth+1): +1 on push, -1 on pop, unchanged when both apply to the same channel. ch_busy_o[k] = (cnt[k] != 0).
REQ-024 SHALL hold ch_rsp_o for non-head channels at '0.

Reset
REQ-025 SHALL, on rst_ni low, immediately set the state to IDLE, rr_q=0, gnt_q=0, the FIFO to empty and all counters to 0.
REQ-026 SHALL drive, during reset, be_req_valid_o=0, be_rsp_ready_o=0, all ch_req_ready_o=0, all ch_rsp_valid_o=0, ch_busy_o=0 and busy_o=0.
REQ-027 SHALL discard in-flight bookkeeping on reset mid-operation; the backend SHALL be reset in the same domain.

Configuration
REQ-028 SHALL, with macro IDMA_CHANNEL_ARBITER_STATS_EN defined, add output ch_jobs_done_o, NumChannels x 32 bits. Each entry is a wrapping count of response handshakes per channel, reset to 0.
REQ-029 SHALL, without the macro, omit the port and the counters entirely.

Structure
REQ-030 SHALL place the grant FSM enum (IDLE, HELD) and the constant MaxChannels=16 in package idma_arb_pkg.
REQ-031 SHALL implement the completion FIFO as one stream_fifo instance (FALL_THROUGH=0, DEPTH=CmplFifoDepth). Arbitration and counters SHALL be inline.

Verification
REQ-032 SHALL cover: channels 0,2 valid, rr_q=0, be_req_ready_i=1 -> ch0 granted, rr_q=1, next cycle ch2 granted.
REQ-033 SHALL cover: ch1 valid with be_req_ready_i=0 for 3 cycles while ch0 rises -> be_req_o stays ch1's job and the handshake goes to ch1.
REQ-034 SHALL cover: CmplFifoDepth=8, 8 requests accepted with no responses -> be_req_valid_o=0 and all ready=0; 1 response -> issue resumes.
REQ-035 SHALL cover: jobs issued ch3, ch1, ch3, then 3 responses -> routed to ch3, ch1, ch3 in order; ch_busy_o = 4'b1010 after issue and 0 at end.
REQ-036 SHALL cover: head ch2 with ch_rsp_ready_i[2]=0 -> be_rsp_ready_o=0, no pop, and ch_rsp_valid_o[0,1,3]=0.
REQ-037 SHALL cover: rst_ni low for 1 cycle with 5 jobs in flight -> busy_o=0 and FIFO empty; with IDMA_CHANNEL_ARBITER_STATS_EN defined, counters read 0.
